inst_fetch_ctrl: RTL and testbench

Instruction fetch sequencer in front of instruction_memory, which has an asynchronous read from byte address i_addr to o_inst.
- Owns the program counter and drives the memory address.
- Registers each fetched word into a one-entry output stage toward decode, using a valid/ready handshake.
- Accepts branch/jump redirects.
- Halts on an all-zero instruction word or an out-of-range PC.

---
 rtl/inst_fetch_ctrl.sv | 156 +++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction fetch sequencer with one-entry valid/ready output stage
//
// Owns the program counter, addresses an asynchronous-read instruction memory,
// and registers each fetched word into a single output slot toward decode.
// Fetch halts on an all-zero instruction word or when the PC leaves the memory.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect to a non-word-aligned target halts fetch and raises o_misalign
//   undefined : redirect targets are word-aligned by clearing bits [1:0]; o_misalign is 0
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   o_mem_addr     byte address to instruction memory (word aligned)
//   i_mem_inst     instruction word read from o_mem_addr, same cycle
//   o_valid        output slot holds an instruction
//   i_ready        decode accepts; transfer on o_valid && i_ready
//   o_inst         registered instruction
//   o_pc           byte address of o_inst
//   i_redirect     load i_redirect_pc as the new PC this cycle
//   i_redirect_pc  redirect target
//   o_halted       fetch is stopped
//   o_misalign     last redirect target was misaligned (trap build only)

`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module inst_fetch_ctrl #(
    parameter int          MEM_SIZE = 1024,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int         ADDR_W   = $clog2(MEM_SIZE)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    output logic [ADDR_W-1:0]      o_mem_addr,
    input  logic [`INST_WIDTH-1:0] i_mem_inst,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [`INST_WIDTH-1:0] o_inst,
    output logic [31:0]            o_pc,
    input  logic                   i_redirect,
    input  logic [31:0]            i_redirect_pc,
    output logic                   o_halted,
    output logic                   o_misalign
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                 state, state_d;
    logic [31:0]            pc, pc_d;
    logic                   valid_d;
    logic [`INST_WIDTH-1:0] inst_d;
    logic [31:0]            opc_d;
    logic                   misalign_q, misalign_d;

    logic consumed;
    logic slot_free;
    logic out_of_range;

    // Memory is word addressed in practice; the low byte-offset bits never reach it.
    assign o_mem_addr   = {pc[ADDR_W-1:2], 2'b00};
    assign o_halted     = (state == ST_HALT);
    assign o_misalign   = misalign_q;

    assign consumed     = o_valid && i_ready;
    assign slot_free    = (state == ST_RUN) && (!o_valid || i_ready);
    assign out_of_range = (pc[31:ADDR_W] != '0);

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        valid_d    = o_valid;
        inst_d     = o_inst;
        opc_d      = o_pc;
        misalign_d = misalign_q;

        if (i_redirect) begin
            // Flush unconditionally: a same-cycle handshake still counts as
            // delivered to decode, but the slot is emptied either way.
            valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            pc_d = i_redirect_pc;
            if (i_redirect_pc[1:0] != 2'b00) begin
                state_d    = ST_HALT;
                misalign_d = 1'b1;
            end else begin
                state_d    = ST_RUN;
                misalign_d = 1'b0;
            end
`else
            pc_d       = i_redirect_pc & 32'hFFFF_FFFC;
            state_d    = ST_RUN;
            misalign_d = 1'b0;
`endif
        end else begin
            case (state)
                ST_BOOT: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (out_of_range) begin
                        // No capture; a held entry stays until decode takes it.
                        state_d = ST_HALT;
                        if (consumed) valid_d = 1'b0;
                    end else if (slot_free) begin
                        if (i_mem_inst == '0) begin
                            // Slot is free, so the current entry (if any) is gone.
                            state_d = ST_HALT;
                            valid_d = 1'b0;
                        end else begin
                            inst_d  = i_mem_inst;
                            opc_d   = {pc[31:2], 2'b00};
                            valid_d = 1'b1;
                            pc_d    = pc + 32'd4;
                        end
                    end
                end
                ST_HALT: begin
                    if (consumed) valid_d = 1'b0;
                end
                default: begin
                    state_d = ST_HALT;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_BOOT;
            pc         <= RESET_PC;
            o_valid    <= 1'b0;
            o_inst     <= '0;
            o_pc       <= '0;
            misalign_q <= 1'b0;
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            o_valid <= valid_d;
            o_inst  <= inst_d;
            o_pc    <= opc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`else
            misalign_q <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - directed self-checking bench for inst_fetch_ctrl

`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module tb_inst_fetch_ctrl;

    localparam int ADDR_W = 10;

    logic                   clk;
    logic                   rst_n;
    logic [ADDR_W-1:0]      mem_addr;
    logic [`INST_WIDTH-1:0] mem_inst;
    logic                   valid;
    logic                   ready;
    logic [`INST_WIDTH-1:0] inst;
    logic [31:0]            pc;
    logic                   redirect;
    logic [31:0]            redirect_pc;
    logic                   halted;
    logic                   misalign;

    logic [31:0] mem [0:255];
    logic [31:0] prog [0:3];

    int pass_cnt  = 0;
    int total_cnt = 0;

    inst_fetch_ctrl #(.MEM_SIZE(1024), .RESET_PC(32'h0)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_mem_addr    (mem_addr),
        .i_mem_inst    (mem_inst),
        .o_valid       (valid),
        .i_ready       (ready),
        .o_inst        (inst),
        .o_pc          (pc),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_halted      (halted),
        .o_misalign    (misalign)
    );

    assign mem_inst = mem[mem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        ready       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({valid, halted, misalign} !== 3'b000 || inst !== 32'h0 || pc !== 32'h0 || mem_addr !== 10'h0)
            $display("FAIL reset_state got v=%0b h=%0b m=%0b inst=%h pc=%h addr=%h want all zero", valid, halted, misalign, inst, pc, mem_addr);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (valid !== 1'b0) $display("FAIL boot_no_capture got valid=%0b want 0", valid);
        else pass_cnt++;
    endtask

    task automatic test_stream_and_halt();
        tick();
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (valid !== 1'b1 || pc !== 32'(4 * i) || inst !== prog[i])
                $display("FAIL stream_%0d got v=%0b pc=%h inst=%h want v=1 pc=%h inst=%h", i, valid, pc, inst, 32'(4 * i), prog[i]);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (valid !== 1'b0 || halted !== 1'b1 || mem_addr !== 10'h010)
            $display("FAIL zero_halt got v=%0b h=%0b addr=%h want v=0 h=1 addr=010", valid, halted, mem_addr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (valid !== 1'b0 || halted !== 1'b1 || mem_addr !== 10'h010)
            $display("FAIL halt_hold got v=%0b h=%0b addr=%h want v=0 h=1 addr=010", valid, halted, mem_addr);
        else pass_cnt++;
    endtask

    task automatic test_restart_from_halt();
        redirect = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        total_cnt++;
        if (halted !== 1'b0 || valid !== 1'b0)
            $display("FAIL restart_flush got h=%0b v=%0b want h=0 v=0", halted, valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (valid !== 1'b1 || inst !== prog[0] || pc !== 32'h0)
            $display("FAIL restart_first got v=%0b inst=%h pc=%h want v=1 inst=%h pc=0", valid, inst, pc, prog[0]);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        do_reset();
        ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (valid !== 1'b1 || inst !== prog[0] || pc !== 32'h0 || mem_addr !== 10'h004)
                $display("FAIL stall_%0d got v=%0b inst=%h pc=%h addr=%h want v=1 inst=%h pc=0 addr=004", i, valid, inst, pc, mem_addr, prog[0]);
            else pass_cnt++;
            tick();
        end
        ready = 1'b1;
        tick();
        total_cnt++;
        if (valid !== 1'b1 || inst !== prog[1] || pc !== 32'h4)
            $display("FAIL resume_1 got v=%0b inst=%h pc=%h want v=1 inst=%h pc=4", valid, inst, pc, prog[1]);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (valid !== 1'b1 || inst !== prog[2] || pc !== 32'h8)
            $display("FAIL resume_2 got v=%0b inst=%h pc=%h want v=1 inst=%h pc=8", valid, inst, pc, prog[2]);
        else pass_cnt++;
    endtask

    task automatic test_redirect_flush();
        do_reset();
        tick();
        tick();
        tick();
        total_cnt++;
        if (valid !== 1'b1 || pc !== 32'h4)
            $display("FAIL pre_redirect got v=%0b pc=%h want v=1 pc=4", valid, pc);
        else pass_cnt++;
        redirect = 1'b1; redirect_pc = 32'h8;
        tick();
        redirect = 1'b0;
        total_cnt++;
        if (valid !== 1'b0 || mem_addr !== 10'h008)
            $display("FAIL redirect_flush got v=%0b addr=%h want v=0 addr=008", valid, mem_addr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (valid !== 1'b1 || inst !== prog[2] || pc !== 32'h8)
            $display("FAIL redirect_target got v=%0b inst=%h pc=%h want v=1 inst=%h pc=8", valid, inst, pc, prog[2]);
        else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        redirect = 1'b1; redirect_pc = 32'h400;
        tick();
        redirect = 1'b0;
        total_cnt++;
        if (valid !== 1'b0 || halted !== 1'b0 || mem_addr !== 10'h000)
            $display("FAIL oor_load got v=%0b h=%0b addr=%h want v=0 h=0 addr=000", valid, halted, mem_addr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (valid !== 1'b0 || halted !== 1'b1)
            $display("FAIL oor_halt got v=%0b h=%0b want v=0 h=1", valid, halted);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (valid !== 1'b0 || halted !== 1'b1)
            $display("FAIL oor_hold got v=%0b h=%0b want v=0 h=1", valid, halted);
        else pass_cnt++;
    endtask

    task automatic test_misalign();
        redirect = 1'b1; redirect_pc = 32'h6;
        tick();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        total_cnt++;
        if (halted !== 1'b1 || misalign !== 1'b1 || valid !== 1'b0)
            $display("FAIL misalign_trap got h=%0b m=%0b v=%0b want h=1 m=1 v=0", halted, misalign, valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (halted !== 1'b1 || misalign !== 1'b1 || valid !== 1'b0)
            $display("FAIL misalign_hold got h=%0b m=%0b v=%0b want h=1 m=1 v=0", halted, misalign, valid);
        else pass_cnt++;
        redirect = 1'b1; redirect_pc = 32'h4;
        tick();
        redirect = 1'b0;
        total_cnt++;
        if (halted !== 1'b0 || misalign !== 1'b0)
            $display("FAIL misalign_clear got h=%0b m=%0b want h=0 m=0", halted, misalign);
        else pass_cnt++;
`else
        total_cnt++;
        if (halted !== 1'b0 || misalign !== 1'b0 || mem_addr !== 10'h004)
            $display("FAIL misalign_align got h=%0b m=%0b addr=%h want h=0 m=0 addr=004", halted, misalign, mem_addr);
        else pass_cnt++;
`endif
        tick();
        total_cnt++;
        if (valid !== 1'b1 || inst !== prog[1] || pc !== 32'h4 || misalign !== 1'b0)
            $display("FAIL misalign_deliver got v=%0b inst=%h pc=%h m=%0b want v=1 inst=%h pc=4 m=0", valid, inst, pc, misalign, prog[1]);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        tick();
        total_cnt++;
        if (valid !== 1'b1 || inst !== prog[2])
            $display("FAIL pre_async got v=%0b inst=%h want v=1 inst=%h", valid, inst, prog[2]);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({valid, halted, misalign} !== 3'b000 || inst !== 32'h0 || pc !== 32'h0 || mem_addr !== 10'h0)
            $display("FAIL async_reset got v=%0b h=%0b m=%0b inst=%h pc=%h addr=%h want all zero", valid, halted, misalign, inst, pc, mem_addr);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        prog[0] = 32'h00108113;
        prog[1] = 32'h00108193;
        prog[2] = 32'h00310233;
        prog[3] = 32'hfe218ae3;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) mem[i] = prog[i];

        test_reset();
        test_stream_and_halt();
        test_restart_from_halt();
        test_stall();
        test_redirect_flush();
        test_out_of_range();
        test_misalign();
        test_async_reset();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
